decoder_n_scan: RTL and testbench

DECODER_N_SCAN -- requirements
Module: decoder_n_scan

---
 rtl/decoder_n_scan.sv | 100 ++++++++++
 tb/tb_decoder_n_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered binary-to-one-hot decoder with an auto-scan mode.
// Direct mode decodes Ip each cycle; scan mode steps the selected index
// every DIV cycles, pulsing Wrap when the index rolls from 2^N-1 back to 0.
// EN=0 blanks the output while holding the scan position so it can resume.
module decoder_n_scan #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                MODE,
  input  logic [N-1:0]        Ip,
  output logic [(1<<N)-1:0]   Op,
  output logic [N-1:0]        Idx,
  output logic                Wrap
);

  localparam int W  = 1 << N;
  // Dwell counter needs at least one bit even when DIV=1 (it then stays 0)
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [N-1:0]  r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_mode_q;
  logic [W-1:0]  r_op;
  logic          r_wrap;

  logic          w_load;
  logic          w_expire;
  logic          w_last_idx;
  logic [N-1:0]  w_idx_inc;

  // One-hot image of a binary index
  function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
    onehot = W'(1) << sel;
  endfunction

  // Classify the current cycle: load from Ip (direct or scan entry), dwell expiry, wrap step
  always_comb begin
    w_load     = 1'b0;
    w_expire   = 1'b0;
    w_last_idx = 1'b0;
    w_idx_inc  = r_idx + N'(1);
    if (!MODE || !r_mode_q) begin
      w_load = 1'b1;
    end else begin
      w_load = 1'b0;
    end
    if (r_cnt == CNT_MAX) begin
      w_expire = 1'b1;
    end else begin
      w_expire = 1'b0;
    end
    if (r_idx == {N{1'b1}}) begin
      w_last_idx = 1'b1;
    end else begin
      w_last_idx = 1'b0;
    end
  end

  // State and registered outputs; reset dominates everything on the same edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_mode_q <= 1'b0;
      r_op     <= '0;
      r_wrap   <= 1'b0;
    end else begin
      // MODE is tracked even while disabled so a paused scan is not seen as a new entry
      r_mode_q <= MODE;
      if (!EN) begin
        r_op   <= '0;
        r_wrap <= 1'b0;
      end else if (w_load) begin
        r_idx  <= Ip;
        r_cnt  <= '0;
        r_op   <= onehot(Ip);
        r_wrap <= 1'b0;
      end else if (w_expire) begin
        r_idx  <= w_idx_inc;
        r_cnt  <= '0;
        r_op   <= onehot(w_idx_inc);
        r_wrap <= w_last_idx;
      end else begin
        // Re-derive Op from idx so the output reappears after a pause
        r_cnt  <= r_cnt + CW'(1);
        r_op   <= onehot(r_idx);
        r_wrap <= 1'b0;
      end
    end
  end

  assign Op   = r_op;
  assign Idx  = r_idx;
  assign Wrap = r_wrap;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Self-checking bench for decoder_n_scan: a table of vectors for an N=3, DIV=4
// instance plus a hand-written rotation sequence for a DIV=1 instance.
module tb_decoder_n_scan;

  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] ip;
    logic [7:0] op;
    logic [2:0] idx;
    logic       wrap;
  } vec_t;

  typedef struct {
    logic [7:0] op;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst_a, en_a, mode_a;
  logic [2:0] ip_a;
  logic [7:0] op_a;
  logic [2:0] idx_a;
  logic       wrap_a;

  logic       rst_b, en_b, mode_b;
  logic [2:0] ip_b;
  logic [7:0] op_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];
  exp_t exp_a_q[$];
  exp_t exp_b_q[$];

  decoder_n_scan #(.N(3), .DIV(4)) u_dut (
    .CLK(CLK), .RST(rst_a), .EN(en_a), .MODE(mode_a), .Ip(ip_a),
    .Op(op_a), .Idx(idx_a), .Wrap(wrap_a)
  );

  decoder_n_scan #(.N(3), .DIV(1)) u_dut1 (
    .CLK(CLK), .RST(rst_b), .EN(en_b), .MODE(mode_b), .Ip(ip_b),
    .Op(op_b), .Idx(idx_b), .Wrap(wrap_b)
  );

  always #5 CLK = ~CLK;

  task automatic add(input logic r, input logic e, input logic m, input logic [2:0] i,
                     input logic [7:0] o, input logic [2:0] x, input logic w);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.ip = i; v.op = o; v.idx = x; v.wrap = w;
    vecs.push_back(v);
  endtask

  task automatic add_rep(input int n, input logic r, input logic e, input logic m,
                         input logic [2:0] i, input logic [7:0] o, input logic [2:0] x,
                         input logic w);
    for (int k = 0; k < n; k++) add(r, e, m, i, o, x, w);
  endtask

  task automatic compare(input string nm, input logic [7:0] aop, input logic [2:0] aidx,
                         input logic awrap, input exp_t e);
    checks++;
    if (aop !== e.op || aidx !== e.idx || awrap !== e.wrap) begin
      failures++;
      $display("FAIL %s: got Op=%h Idx=%0d Wrap=%b, expected Op=%h Idx=%0d Wrap=%b",
               nm, aop, aidx, awrap, e.op, e.idx, e.wrap);
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   wraps;
    logic [7:0] one;

    rst_a = 1'b1; en_a = 1'b1; mode_a = 1'b1; ip_a = 3'd5;
    rst_b = 1'b1; en_b = 1'b0; mode_b = 1'b0; ip_b = 3'd0;

    // Reset held two cycles with EN/MODE/Ip active
    add_rep(2, 1'b1, 1'b1, 1'b1, 3'd5, 8'h00, 3'd0, 1'b0);
    // Disabled direct mode
    add(1'b0, 1'b0, 1'b0, 3'd7, 8'h00, 3'd0, 1'b0);
    // Direct decode of Ip = 1..7
    one = 8'h01;
    for (int k = 1; k < 8; k++) add(1'b0, 1'b1, 1'b0, 3'(k), one << k, 3'(k), 1'b0);
    // Scan entry at 6; later Ip changes are ignored
    add(1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 3'd6, 1'b0);
    add_rep(3, 1'b0, 1'b1, 1'b1, 3'd1, 8'h40, 3'd6, 1'b0);
    add_rep(4, 1'b0, 1'b1, 1'b1, 3'd2, 8'h80, 3'd7, 1'b0);
    add(1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b1);
    add_rep(3, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0);
    add_rep(4, 1'b0, 1'b1, 1'b1, 3'd0, 8'h02, 3'd1, 1'b0);
    // First dwell cycle at index 2, then pause 3 cycles and resume
    add(1'b0, 1'b1, 1'b1, 3'd0, 8'h04, 3'd2, 1'b0);
    add_rep(3, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 3'd2, 1'b0);
    add_rep(3, 1'b0, 1'b1, 1'b1, 3'd0, 8'h04, 3'd2, 1'b0);
    add_rep(4, 1'b0, 1'b1, 1'b1, 3'd0, 8'h08, 3'd3, 1'b0);
    add_rep(4, 1'b0, 1'b1, 1'b1, 3'd0, 8'h10, 3'd4, 1'b0);
    add_rep(4, 1'b0, 1'b1, 1'b1, 3'd0, 8'h20, 3'd5, 1'b0);
    // Reset on the same edge as the dwell expiry at index 5, then scan entry at 3
    add(1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0);
    add_rep(2, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 3'd3, 1'b0);
    // Scan entry with Ip=0 must not pulse Wrap
    add(1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0);
    // Reset on the edge that would wrap 7 -> 0
    add(1'b0, 1'b1, 1'b0, 3'd7, 8'h80, 3'd7, 1'b0);
    add_rep(4, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 3'd7, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd7, 8'h00, 3'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst; en_a = vecs[i].en; mode_a = vecs[i].mode; ip_a = vecs[i].ip;
      e.op = vecs[i].op; e.idx = vecs[i].idx; e.wrap = vecs[i].wrap;
      exp_a_q.push_back(e);
      @(posedge CLK);
      #1;
      compare($sformatf("div4_vec%0d", i), op_a, idx_a, wrap_a, exp_a_q.pop_front());
    end

    // DIV=1 instance: reset, scan entry at 0, then one step per cycle
    en_a = 1'b0; rst_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b1; mode_b = 1'b1; ip_b = 3'd4;
    e.op = 8'h00; e.idx = 3'd0; e.wrap = 1'b0;
    exp_b_q.push_back(e);
    @(posedge CLK);
    #1;
    compare("div1_reset", op_b, idx_b, wrap_b, exp_b_q.pop_front());

    rst_b = 1'b0; ip_b = 3'd0;
    e.op = 8'h01; e.idx = 3'd0; e.wrap = 1'b0;
    exp_b_q.push_back(e);
    @(posedge CLK);
    #1;
    compare("div1_entry", op_b, idx_b, wrap_b, exp_b_q.pop_front());

    wraps = 0;
    ip_b = 3'd5;
    for (int k = 1; k <= 16; k++) begin
      e.idx  = 3'(k % 8);
      e.op   = one << (k % 8);
      e.wrap = ((k % 8) == 0);
      exp_b_q.push_back(e);
      @(posedge CLK);
      #1;
      if (wrap_b === 1'b1) wraps++;
      compare($sformatf("div1_step%0d", k), op_b, idx_b, wrap_b, exp_b_q.pop_front());
    end
    checks++;
    if (wraps != 2) begin
      failures++;
      $display("FAIL div1_wrap_count: got %0d, expected 2", wraps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
